demux1to8_nbit_buf: RTL and testbench

- 1-to-8 N-bit demultiplexer with registered outputs; the write/distribution counterpart of the 8-to-1 N-bit select mux.
- Accepts one word per cycle on a valid/ready input, with a 3-bit destination select.
- Parks each word in a one-entry holding register per destination. Each destination drains independently through its own valid/ready handshake.
- Used wherever one producer feeds up to eight consumers (register-bank write fan-out, per-unit result routing).

---
 rtl/demux1to8_nbit_buf_if.sv | 56 +++++
 rtl/demux1to8_nbit_buf.sv | 148 ++++++++++++++
 tb/tb_demux1to8_nbit_buf.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/demux1to8_nbit_buf_if.sv
//============================================================================
// Module      : demux1to8_nbit_buf_if
// Description : Bundle of the producer handshake, the eight destination
//               holding-register outputs with their handshakes, and the
//               accepted-word counter of demux1to8_nbit_buf.
//
//               Signals
//                 in_valid  producer -> block   input word present
//                 in_ready  block -> producer   block accepts this cycle
//                 S         producer -> block   destination select (3 bits)
//                 I         producer -> block   input data word (N bits)
//                 F00..F07  block -> consumers  holding registers (N bits)
//                 out_valid block -> consumers  bit k: F0k holds a word
//                 out_ready consumers -> block  bit k: consumer k takes F0k
//                 count     block -> observer   accepted-word counter
//
//               Modports
//                 master : the environment (producer and consumers)
//                 slave  : the demultiplexer itself
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

interface demux1to8_nbit_buf_if #(
   parameter int N = 1
);
   logic          in_valid;
   logic          in_ready;
   logic [2:0]    S;
   logic [N-1:0]  I;
   logic [N-1:0]  F00;
   logic [N-1:0]  F01;
   logic [N-1:0]  F02;
   logic [N-1:0]  F03;
   logic [N-1:0]  F04;
   logic [N-1:0]  F05;
   logic [N-1:0]  F06;
   logic [N-1:0]  F07;
   logic [7:0]    out_valid;
   logic [7:0]    out_ready;
   logic [7:0]    count;

   modport master (
      output in_valid, S, I, out_ready,
      input  in_ready, F00, F01, F02, F03, F04, F05, F06, F07,
             out_valid, count
   );

   modport slave (
      input  in_valid, S, I, out_ready,
      output in_ready, F00, F01, F02, F03, F04, F05, F06, F07,
             out_valid, count
   );
endinterface

`default_nettype wire

// File: rtl/demux1to8_nbit_buf.sv
//============================================================================
// Module      : demux1to8_nbit_buf
// Description : 1-to-8 N-bit demultiplexer with registered outputs.
//               One word per cycle is accepted on a valid/ready input and
//               parked in a one-entry holding register for the selected
//               destination. Every destination drains independently
//               through its own valid/ready handshake. A slot that is being
//               drained can be reloaded in the same cycle without a bubble.
//
//               Ports
//                 clk      in   rising-edge clock
//                 reset_n  in   asynchronous active-low reset
//                 bus      slave modport of demux1to8_nbit_buf_if
//                          (in_valid/in_ready/S/I, F00..F07,
//                           out_valid/out_ready, count)
//
//               Parameters
//                 N        data width of the input and of every output word
//
//               Build options
//                 DEMUX_AUTOINC_EN  when defined, an internal 3-bit
//                                   round-robin pointer replaces S as the
//                                   destination; S is then ignored.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module demux1to8_nbit_buf #(
   parameter int N = 1
) (
   input  wire logic             clk,
   input  wire logic             reset_n,
   demux1to8_nbit_buf_if.slave   bus
);

   localparam int C_NUM_SLOTS = 8;

   // -----------------------------------------------------------------------
   // State
   // -----------------------------------------------------------------------
   logic [N-1:0]  r_data [C_NUM_SLOTS];
   logic [7:0]    r_valid;
   logic [7:0]    r_count;

   // -----------------------------------------------------------------------
   // Combinational control
   // -----------------------------------------------------------------------
   logic [2:0]    w_dest;
   logic          w_in_ready;
   logic          w_accept;
   logic [7:0]    w_load;
   logic [7:0]    w_drain;

`ifdef DEMUX_AUTOINC_EN
   // Round-robin destination pointer. It advances only on an accepted word,
   // so a full slot at the pointer stalls the input even if other slots are
   // empty; words are never steered around a blocked consumer.
   logic [2:0]    r_ptr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ptr <= 3'b000;
      end else if (w_accept) begin
         r_ptr <= r_ptr + 3'd1;
      end
   end

   assign w_dest = r_ptr;
`else
   assign w_dest = bus.S;
`endif

   // A slot can take a new word when it is empty or is handing its current
   // word to the consumer in this very cycle. The path from S/out_ready to
   // in_ready is combinational on purpose: it is what allows drain and
   // reload of one slot in a single cycle.
   assign w_in_ready = ~r_valid[w_dest] | bus.out_ready[w_dest];
   assign w_accept   = bus.in_valid & w_in_ready;

   // One-hot load strobe for the addressed slot.
   assign w_load  = 8'(w_accept) << w_dest;

   // out_ready on an empty slot is masked off here and has no effect.
   assign w_drain = r_valid & bus.out_ready;

   // -----------------------------------------------------------------------
   // Holding registers
   // An empty slot keeps its last value; consumers qualify with out_valid.
   // A full slot that is not drained never sees a load (in_ready is low for
   // it), so its data is held stable.
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < C_NUM_SLOTS; k++) begin
            r_data[k] <= '0;
         end
      end else begin
         for (int k = 0; k < C_NUM_SLOTS; k++) begin
            if (w_load[k]) begin
               r_data[k] <= bus.I;
            end
         end
      end
   end

   // -----------------------------------------------------------------------
   // Occupancy flags
   // Load takes priority over drain, so a slot drained and reloaded in the
   // same cycle stays valid. Drains of other slots run in parallel.
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_valid <= 8'h00;
      end else begin
         r_valid <= (r_valid & ~w_drain) | w_load;
      end
   end

   // -----------------------------------------------------------------------
   // Accepted-word counter, free-running with natural wrap at 8 bits.
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= 8'h00;
      end else if (w_accept) begin
         r_count <= r_count + 8'd1;
      end
   end

   // -----------------------------------------------------------------------
   // Outputs
   // -----------------------------------------------------------------------
   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_valid;
   assign bus.count     = r_count;

   assign bus.F00 = r_data[0];
   assign bus.F01 = r_data[1];
   assign bus.F02 = r_data[2];
   assign bus.F03 = r_data[3];
   assign bus.F04 = r_data[4];
   assign bus.F05 = r_data[5];
   assign bus.F06 = r_data[6];
   assign bus.F07 = r_data[7];

endmodule

`default_nettype wire

// File: tb/tb_demux1to8_nbit_buf.sv
//============================================================================
// Module      : tb_demux1to8_nbit_buf
// Description : Self-checking bench for demux1to8_nbit_buf (N = 8).
//               Directed scenarios plus a randomized producer/consumer phase.
//               A reference model keeps one queue of expected words per
//               destination; a negedge monitor compares DUT outputs with the
//               queue heads and updates the queues from observed handshakes.
//               Define DEMUX_AUTOINC_EN to exercise the round-robin build.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_demux1to8_nbit_buf;

   localparam int N = 8;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   always #5 clk = ~clk;

   demux1to8_nbit_buf_if #(.N(N)) bus ();

   demux1to8_nbit_buf #(.N(N)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: per-destination queue of undelivered words.
   logic [N-1:0] q [8][$];
   logic [7:0]   m_count = 8'h00;
   logic [2:0]   m_ptr   = 3'b000;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [N-1:0] get_f(input int k);
      case (k)
         0: return bus.F00;
         1: return bus.F01;
         2: return bus.F02;
         3: return bus.F03;
         4: return bus.F04;
         5: return bus.F05;
         6: return bus.F06;
         default: return bus.F07;
      endcase
   endfunction

   // -----------------------------------------------------------------------
   // Monitor / scoreboard (samples at the falling edge)
   // -----------------------------------------------------------------------
   always @(negedge clk) begin
      logic [7:0] exp_valid;
      logic [2:0] d;
      logic       exp_ready;
      if (!reset_n) begin
         for (int k = 0; k < 8; k++) q[k].delete();
         m_count = 8'h00;
         m_ptr   = 3'b000;
      end else begin
         for (int k = 0; k < 8; k++) exp_valid[k] = (q[k].size() != 0);
         chk("mon_out_valid", 64'(bus.out_valid), 64'(exp_valid));
         for (int k = 0; k < 8; k++) begin
            if (q[k].size() != 0) chk($sformatf("mon_F0%0d", k), 64'(get_f(k)), 64'(q[k][0]));
         end
         chk("mon_count", 64'(bus.count), 64'(m_count));
`ifdef DEMUX_AUTOINC_EN
         d = m_ptr;
`else
         d = bus.S;
`endif
         exp_ready = (q[d].size() == 0) || bus.out_ready[d];
         chk("mon_in_ready", 64'(bus.in_ready), 64'(exp_ready));
         // Deliveries happen before the new word lands in the same slot.
         for (int k = 0; k < 8; k++) begin
            if (bus.out_ready[k] && q[k].size() != 0) void'(q[k].pop_front());
         end
         if (bus.in_valid && exp_ready) begin
            q[d].push_back(bus.I);
            m_count = m_count + 8'd1;
            m_ptr   = m_ptr + 3'd1;
         end
      end
   end

   // -----------------------------------------------------------------------
   // Stimulus helpers: inputs change 1 time unit after the rising edge.
   // -----------------------------------------------------------------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [2:0] s, input logic [N-1:0] i,
                        input logic [7:0] ordy);
      bus.in_valid  = v;
      bus.S         = s;
      bus.I         = i;
      bus.out_ready = ordy;
   endtask

   task automatic do_reset();
      reset_n      = 1'b0;
      bus.in_valid = 1'b0;
      step();
      step();
      reset_n = 1'b1;
   endtask

   logic pend;

   initial begin
      drive(1'b1, 3'd5, '1, 8'h00);
      reset_n = 1'b0;
      step();
      step();
      // Reset state with in_valid held high.
      for (int k = 0; k < 8; k++) chk($sformatf("rst_F0%0d", k), 64'(get_f(k)), 64'h0);
      chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
      chk("rst_count", 64'(bus.count), 64'h0);
      reset_n      = 1'b1;
      bus.in_valid = 1'b0;
      for (int s = 0; s < 8; s++) begin
         step();
         bus.S = 3'(s);
         #1;
         chk($sformatf("rel_in_ready_S%0d", s), 64'(bus.in_ready), 64'h1);
      end
      step();

`ifndef DEMUX_AUTOINC_EN
      // Single word to slot 5, then a blocked resend.
      drive(1'b1, 3'd5, 8'hA5, 8'h00);
      step();
      chk("s5_F05", 64'(bus.F05), 64'hA5);
      chk("s5_out_valid", 64'(bus.out_valid), 64'h20);
      chk("s5_count", 64'(bus.count), 64'h1);
      bus.I = 8'h3C;
      repeat (5) begin
         #1;
         chk("s5_stall_in_ready", 64'(bus.in_ready), 64'h0);
         chk("s5_hold_F05", 64'(bus.F05), 64'hA5);
         step();
      end
      drive(1'b0, 3'd0, 8'h00, 8'h20);
      step();

      // Drain and reload of slot 2 in one cycle.
      drive(1'b1, 3'd2, 8'h11, 8'h00);
      step();
      drive(1'b1, 3'd2, 8'h22, 8'h04);
      #1;
      chk("s2_reload_in_ready", 64'(bus.in_ready), 64'h1);
      step();
      chk("s2_F02", 64'(bus.F02), 64'h22);
      chk("s2_out_valid2", 64'(bus.out_valid[2]), 64'h1);
      chk("s2_count", 64'(bus.count), 64'h3);
      drive(1'b0, 3'd0, 8'h00, 8'hFF);
      step();

      // Fill all slots, drain together, then count wrap.
      do_reset();
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, 3'(k), 8'(k + 1), 8'h00);
         step();
      end
      bus.in_valid = 1'b0;
      chk("fill_out_valid", 64'(bus.out_valid), 64'hFF);
      for (int k = 0; k < 8; k++) chk($sformatf("fill_F0%0d", k), 64'(get_f(k)), 64'(k + 1));
      bus.out_ready = 8'hFF;
      step();
      chk("drain_out_valid", 64'(bus.out_valid), 64'h00);
      chk("drain_count", 64'(bus.count), 64'h8);
      repeat (250) begin
         drive(1'b1, 3'($urandom), N'($urandom), 8'hFF);
         step();
      end
      bus.in_valid = 1'b0;
      chk("wrap_count", 64'(bus.count), 64'h02);
      step();

      // Asynchronous reset with slots 1,3,4,6 occupied.
      drive(1'b0, 3'd0, 8'h00, 8'hFF);
      step();
      foreach (q[k]) begin
         if (k == 1 || k == 3 || k == 4 || k == 6) begin
            drive(1'b1, 3'(k), N'($urandom), 8'h00);
            step();
         end
      end
      bus.in_valid = 1'b0;
      chk("pre_arst_out_valid", 64'(bus.out_valid), 64'h5A);
      #1;
      reset_n = 1'b0;
      #1;
      chk("arst_out_valid", 64'(bus.out_valid), 64'h00);
      chk("arst_count", 64'(bus.count), 64'h00);
      step();
      step();
      reset_n = 1'b1;
      step();
`else
      // Round-robin: nine words with S held at 3, every slot drained.
      for (int i = 1; i <= 9; i++) begin
         drive(1'b1, 3'd3, 8'(i), (i == 9) ? 8'hFE : 8'hFF);
         step();
         chk($sformatf("rr_word%0d_slot", i), 64'(get_f((i - 1) % 8)), 64'(i));
      end
      // Slot 0 stays full; pointer at 1 still accepts.
      drive(1'b1, 3'd3, 8'h40, 8'hFC);
      #1;
      chk("rr_ptr1_in_ready", 64'(bus.in_ready), 64'h1);
      step();
      chk("rr_F01", 64'(bus.F01), 64'h40);
      chk("rr_out_valid1", 64'(bus.out_valid[1]), 64'h1);
      for (int j = 0; j < 6; j++) begin
         drive(1'b1, 3'd3, 8'(8'h50 + j), 8'hFC);
         step();
      end
      // Pointer wrapped to full slot 0: stall although slots 2..7 are empty.
      drive(1'b1, 3'd3, 8'h77, 8'hFC);
      #1;
      chk("rr_ptr0_stall", 64'(bus.in_ready), 64'h0);
      step();
      chk("rr_F00_hold", 64'(bus.F00), 64'h09);
      drive(1'b0, 3'd0, 8'h00, 8'hFF);
      step();
`endif

      // Randomized producer/consumer traffic; producer holds until accepted.
      pend = 1'b0;
      bus.in_valid = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (!pend && $urandom_range(3) != 0) begin
            pend  = 1'b1;
            bus.S = 3'($urandom);
            bus.I = N'($urandom);
         end
         bus.in_valid  = pend;
         bus.out_ready = 8'($urandom) & 8'($urandom);
         #3;
         if (pend && bus.in_ready) pend = 1'b0;
         step();
      end
      drive(1'b0, 3'd0, 8'h00, 8'hFF);
      step();
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
